// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci LFSR random-word generator.
// Each output word is built from OUT_WIDTH fresh shifts and is handed over
// on a valid/ready interface with back-pressure. The register can be
// reloaded at runtime (seed_load) or returned to SEED (clear).
// Optional feature macro: LFSR_LOCKUP_GUARD_EN. When it is defined, an
// all-zero register or a zero seed is replaced by SEED and lockup pulses
// for one cycle. When it is undefined, lockup is tied low.
module lfsr_stream #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hBEEF,
  parameter int               OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 run,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 lockup
);

  localparam int            CW       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [WIDTH-1:0]     r;
  logic [CW-1:0]        cnt;

  logic                 stall;
  logic                 shift_en;
  logic                 complete;
  logic                 accept;
  logic                 lock_shift;
  logic                 lock_load;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     r_step;
  logic [WIDTH-1:0]     r_load;

  logic [WIDTH-1:0]     r_next;
  logic [CW-1:0]        cnt_next;
  logic                 valid_next;
  logic [OUT_WIDTH-1:0] data_next;
  logic                 lockup_next;

  // Shift enable, feedback and lock-up substitution for the current cycle.
  always_comb begin
    stall    = out_valid && !out_ready;
    shift_en = run && !stall && !clear && !seed_load;
    accept   = out_valid && out_ready;
    complete = shift_en && (cnt == CNT_LAST);
    r_shift  = {r[WIDTH-2:0], ^(r & TAPS)};
`ifdef LFSR_LOCKUP_GUARD_EN
    lock_shift = shift_en && (r == {WIDTH{1'b0}});
    lock_load  = seed_load && !clear && (seed_in == {WIDTH{1'b0}});
`else
    lock_shift = 1'b0;
    lock_load  = 1'b0;
`endif
    r_step = lock_shift ? SEED : r_shift;
    r_load = lock_load ? SEED : seed_in;
  end

  // Next-state selection: clear beats seed_load, seed_load beats shifting.
  always_comb begin
    r_next      = r;
    cnt_next    = cnt;
    valid_next  = out_valid;
    data_next   = out_data;
    lockup_next = 1'b0;
    if (clear) begin
      r_next     = SEED;
      cnt_next   = CNT_ZERO;
      valid_next = 1'b0;
    end else begin
      if (seed_load) begin
        r_next   = r_load;
        cnt_next = CNT_ZERO;
      end else if (shift_en) begin
        r_next   = r_step;
        cnt_next = complete ? CNT_ZERO : (cnt + CW'(1));
      end else begin
        r_next   = r;
        cnt_next = cnt;
      end
      // A completing word overwrites one being accepted in the same cycle.
      if (complete) begin
        valid_next = 1'b1;
        data_next  = r_step[OUT_WIDTH-1:0];
      end else if (accept) begin
        valid_next = 1'b0;
      end else begin
        valid_next = out_valid;
      end
      lockup_next = lock_shift || lock_load;
    end
  end

  // State and registered outputs, asynchronously reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r         <= SEED;
      cnt       <= CNT_ZERO;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {OUT_WIDTH{1'b0}};
      lockup    <= 1'b0;
    end else begin
      r         <= r_next;
      cnt       <= cnt_next;
      busy      <= (cnt_next != CNT_ZERO);
      out_valid <= valid_next;
      out_data  <= data_next;
      lockup    <= lockup_next;
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: directed scenarios plus a randomized
// run/out_ready phase. Accepted words are checked by a monitor against a
// queue of words predicted by a bit-level reference model.
module tb_lfsr_stream;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        run;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        lockup;

  logic        run8;
  logic        ready8;
  logic        clear8;
  logic        seed_load8;
  logic [7:0]  seed_in8;
  logic [0:0]  data8;
  logic        valid8;
  logic        busy8;
  logic        lockup8;

  int          checks;
  int          passes;
  logic        mon_en;
  logic        mon8_en;
  logic [3:0]  exp_q[$];
  logic        exp8_q[$];
  logic [15:0] m_r;
  logic [7:0]  m8;

  lfsr_stream dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .seed_load(seed_load),
    .seed_in(seed_in), .run(run), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .lockup(lockup)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_WIDTH(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .clear(clear8), .seed_load(seed_load8),
    .seed_in(seed_in8), .run(run8), .out_ready(ready8), .out_data(data8),
    .out_valid(valid8), .busy(busy8), .lockup(lockup8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference step: feedback bit is the parity of the tapped bits.
  function automatic logic [15:0] step16(input logic [15:0] v);
    int ones;
`ifdef LFSR_LOCKUP_GUARD_EN
    if (v == 16'h0000) return 16'hBEEF;
`endif
    ones = $countones(v & 16'hB400);
    return (v * 16'd2) + 16'(ones % 2);
  endfunction

  function automatic logic [7:0] step8(input logic [7:0] v);
    int ones;
    ones = $countones(v & 8'hB8);
    return (v * 8'd2) + 8'(ones % 2);
  endfunction

  // A word is the low four bits of the register after four fresh shifts.
  task automatic next_word(output logic [3:0] w);
    for (int k = 0; k < 4; k++) m_r = step16(m_r);
    w = m_r[3:0];
  endtask

  task automatic push_words(input int n);
    logic [3:0] w;
    for (int k = 0; k < n; k++) begin
      next_word(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0; mon8_en = 1'b0;
    run = 1'b0; out_ready = 1'b0; clear = 1'b0; seed_load = 1'b0; seed_in = 16'h0000;
    run8 = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_r", 32'(dut.r), 32'hBEEF);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    exp8_q.delete();
    m_r = 16'hBEEF;
  endtask

  task automatic end_phase(input string name);
    run = 1'b0;
    tick();
    tick();
    mon_en = 1'b0;
    out_ready = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor for the default instance: one pop per accepted word.
  always @(negedge clk) begin
    logic [3:0] w;
    if (mon_en && reset_n && out_valid && out_ready && !clear && !seed_load) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: got word 0x%0h, expected none", out_data);
      end else begin
        w = exp_q.pop_front();
        chk("sb_word", 32'(out_data), 32'(w));
      end
    end
  end

  // Scoreboard monitor for the 8-bit / 1-bit-word instance.
  always @(negedge clk) begin
    logic b;
    if (mon8_en && reset_n && valid8 && ready8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        $display("FAIL sb8_underflow: got bit %0d, expected none", data8);
      end else begin
        b = exp8_q.pop_front();
        chk("sb8_bit", 32'(data8), 32'(b));
      end
    end
  end

  initial begin
    logic [3:0]  w;
    logic [15:0] rs;
    int          first;
    checks = 0; passes = 0;
    reset_n = 1'b1;
    clear8 = 1'b0; seed_load8 = 1'b0; seed_in8 = 8'h00; ready8 = 1'b1;
    mon_en = 1'b0; mon8_en = 1'b0;

    // Defaults: reset values, register trajectory, first two words.
    do_reset();
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lockup", 32'(lockup), 32'd0);
    push_words(2);
    mon_en = 1'b1; run = 1'b1; out_ready = 1'b1;
    tick(); chk("r1", 32'(dut.r), 32'h7DDE); chk("busy1", 32'(busy), 32'd1);
    tick(); chk("r2", 32'(dut.r), 32'hFBBD);
    tick(); chk("r3", 32'(dut.r), 32'hF77B); chk("valid_early", 32'(out_valid), 32'd0);
    tick(); chk("r4", 32'(dut.r), 32'hEEF6); chk("valid_w1", 32'(out_valid), 32'd1);
    chk("data_w1", 32'(out_data), 32'h6); chk("busy_w1", 32'(busy), 32'd0);
    tick(); chk("valid_pulse", 32'(out_valid), 32'd0);
    tick(); tick(); tick();
    chk("r8", 32'(dut.r), 32'hEF6F); chk("data_w2", 32'(out_data), 32'hF);
    end_phase("drain_defaults");

    // Back-pressure: word held, register frozen while out_ready is low.
    do_reset();
    push_words(2);
    mon_en = 1'b1; run = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h6);
      chk("stall_r", 32'(dut.r), 32'hEEF6);
      tick();
    end
    out_ready = 1'b1;
    tick(); chk("accept_drop", 32'(out_valid), 32'd0);
    tick(); tick(); tick();
    chk("after_stall_valid", 32'(out_valid), 32'd1);
    chk("after_stall_data", 32'(out_data), 32'hF);
    end_phase("drain_backpressure");

    // Pause mid-word: run low holds r and the bit count.
    do_reset();
    push_words(1);
    mon_en = 1'b1; run = 1'b1; out_ready = 1'b1;
    tick(); tick();
    chk("pause_r", 32'(dut.r), 32'hFBBD); chk("pause_busy", 32'(busy), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("paused_r", 32'(dut.r), 32'hFBBD);
      chk("paused_busy", 32'(busy), 32'd1);
    end
    run = 1'b1;
    tick(); tick();
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_data", 32'(out_data), 32'h6);
    end_phase("drain_pause");

    // clear beats seed_load; seed_load keeps a pending word.
    do_reset();
    run = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    clear = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    chk("clr_r", 32'(dut.r), 32'hBEEF); chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    clear = 1'b0;
    tick();
    chk("load_r", 32'(dut.r), 32'h1234);
    seed_load = 1'b0;
    m_r = 16'h1234;
    next_word(w);
    for (int i = 0; i < 4; i++) tick();
    chk("seeded_valid", 32'(out_valid), 32'd1);
    chk("seeded_data", 32'(out_data), 32'(w));
    run = 1'b0; seed_load = 1'b1; seed_in = 16'hACE1;
    tick();
    seed_load = 1'b0;
    chk("load2_r", 32'(dut.r), 32'hACE1);
    chk("load2_keep_valid", 32'(out_valid), 32'd1);
    chk("load2_keep_data", 32'(out_data), 32'(w));

    // Zero seed handling.
    do_reset();
    seed_in = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("zero_guard_r", 32'(dut.r), 32'hBEEF);
    chk("zero_guard_pulse", 32'(lockup), 32'd1);
    tick();
    chk("zero_guard_once", 32'(lockup), 32'd0);
    m_r = 16'hBEEF;
`else
    chk("zero_r", 32'(dut.r), 32'h0000);
    chk("zero_lockup", 32'(lockup), 32'd0);
    m_r = 16'h0000;
`endif
    push_words(3);
    mon_en = 1'b1; run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("zero_run_lockup", 32'(lockup), 32'd0);
    end
    end_phase("drain_zero");

    // Randomized run / out_ready against the word model.
    do_reset();
    rs = 16'($urandom_range(1, 65535));
    seed_in = rs; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_r = rs;
    push_words(40);
    mon_en = 1'b1;
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
      run = ($urandom_range(0, 9) < 7);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    run = 1'b0; out_ready = 1'b0; mon_en = 1'b0;
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // 8-bit register, 1-bit words: full period and continuous valid.
    do_reset();
    m8 = 8'h01;
    for (int i = 0; i < 255; i++) begin
      m8 = step8(m8);
      exp8_q.push_back(m8[0]);
    end
    first = 0;
    mon8_en = 1'b1; run8 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (valid8 !== 1'b1) chk("sweep_valid", 32'(valid8), 32'd1);
      if (dut8.r == 8'h01 && first == 0) first = i;
    end
    chk("sweep_period", 32'(first), 32'd255);
    @(negedge clk);
    #1;
    mon8_en = 1'b0; run8 = 1'b0;
    chk("sweep_drain", 32'(exp8_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
